// File: rtl/fa4_seq_ctrl.sv
// fa4_seq_ctrl: nibble-serial W-bit add/subtract built on one shared 4-bit ripple slice.
// Latency: result valid NIBBLES cycles after the accept edge; accepts at most one request per NIBBLES+2 cycles.
// Backpressure: the result is held in DONE until out_ready; no new request is accepted until it is consumed.
//
// Ports:
//   clk, rst_n              single clock, synchronous active-low reset
//   in_valid/in_ready       request handshake carrying a, b, ci, sub
//   out_valid/out_ready     response handshake carrying s, co
//   busy                    high whenever the sequencer is not idle

// fa4: 4-bit ripple-carry adder slice shared by the sequencer.
// Latency: combinational.
// Backpressure: none.
//
// Ports: i_a, i_b operands; i_ci carry-in; o_s sum; o_co carry-out.
module fa4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_ci,
    output logic [3:0] o_s,
    output logic       o_co
);

    logic [4:0] w_c;

    assign w_c[0] = i_ci;

    for (genvar g = 0; g < 4; g++) begin : g_fa
        assign o_s[g]     = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_co = w_c[4];

endmodule

module fa4_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   ci,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   s,
    output logic                   co,
    output logic                   busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // Operand b is stored already inverted for subtraction, so the slice
    // only ever adds: a - b == a + ~b + 1 with the initial carry forced to 1.
    logic [W-1:0]    r_opa;
    logic [W-1:0]    r_opb;
    logic [W-1:0]    r_acc;
    logic            r_carry;
    logic [IW-1:0]   r_idx;

    logic [W-1:0]    r_s;
    logic            r_co;
    logic            r_out_valid;

    logic            w_accept;
    logic            w_last;
    logic [IW+1:0]   w_base;
    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic [3:0]      w_slice_s;
    logic            w_slice_co;
    logic [W-1:0]    w_acc_nxt;

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_last   = (r_idx == LAST_IDX);

    // Bit offset of the active nibble.
    assign w_base   = {r_idx, 2'b00};
    assign w_a_nib  = r_opa[w_base +: 4];
    assign w_b_nib  = r_opb[w_base +: 4];

    fa4 fa4_inst (
        .i_a  (w_a_nib),
        .i_b  (w_b_nib),
        .i_ci (r_carry),
        .o_s  (w_slice_s),
        .o_co (w_slice_co)
    );

    // Accumulator with the current nibble merged in; on the last slice this
    // is the complete result, so it can be loaded into s on the same edge.
    always_comb begin
        w_acc_nxt              = r_acc;
        w_acc_nxt[w_base +: 4] = w_slice_s;
    end

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: state-decoded outputs
    // ---------------------------------------------------------------
    always_comb begin
        in_ready = (r_state == ST_IDLE);
        busy     = (r_state != ST_IDLE);
    end

    // ---------------------------------------------------------------
    // Datapath and registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_opa       <= '0;
            r_opb       <= '0;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_s         <= '0;
            r_co        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_opa   <= a;
                        r_opb   <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : ci;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_nxt;
                    r_carry <= w_slice_co;
                    if (w_last) begin
                        r_s         <= w_acc_nxt;
                        r_co        <= w_slice_co;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    // s/co stay untouched here so they keep the last result
                    // after consumption.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign co        = r_co;

endmodule
